riscv_v_stage_rx_buffer: RTL and testbench

- Receiving end of a fixed-latency `riscv_v_stage` delay line, which runs with its enable tied high.
- Issues credit-based grants to the producer feeding the stage input, and absorbs the delayed beats in a FIFO.
- Presents the beats to a consumer over a valid/ready handshake.
- Guarantees no beat is ever lost when the consumer stalls, whatever the pipeline latency.

---
 rtl/riscv_v_stage_rx_buffer.sv | 165 ++++++++++++++++
 tb/tb_riscv_v_stage_rx_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_stage_rx_buffer.sv
// Receive buffer behind a fixed-latency riscv_v_stage delay line: credit-based
// launch grants upstream, FIFO absorption of delayed beats, valid/ready downstream.

module riscv_v_stage_rx_buffer #(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 4,
  parameter int NUM_STAGES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         up_req,
  output logic                         up_grant,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]     count_r, inflight_r, count_nx, inflight_nx;
  logic              proto_r, proto_nx;
  logic              launch_s, arrive_s, spurious_s, pop_s, credit_ok_s;
  logic [CW:0]       used_s;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // A pop never returns a credit in the same cycle; only registered occupancy counts.
  assign used_s      = {1'b0, count_r} + {1'b0, inflight_r};
  assign credit_ok_s = (used_s < DEPTH_W);
  assign up_grant    = up_req && !flush && credit_ok_s;
  assign launch_s    = up_grant;
  assign arrive_s    = in_valid && (inflight_r != {CW{1'b0}}) && !flush;
  assign spurious_s  = in_valid && (inflight_r == {CW{1'b0}}) && !flush;
  assign pop_s       = (count_r != {CW{1'b0}}) && out_ready && !flush;

  assign out_valid = (count_r != {CW{1'b0}});
  assign out_data  = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign inflight  = inflight_r;
  assign proto_err = proto_r;

  // Next-state for occupancy, credits, pointers and the sticky error flag.
  always_comb begin
    count_nx    = count_r;
    inflight_nx = inflight_r;
    wr_ptr_nx   = wr_ptr_r;
    rd_ptr_nx   = rd_ptr_r;
    proto_nx    = proto_r | spurious_s;
    if (flush) begin
      count_nx    = {CW{1'b0}};
      inflight_nx = {CW{1'b0}};
      wr_ptr_nx   = {PW{1'b0}};
      rd_ptr_nx   = {PW{1'b0}};
    end else begin
      case ({launch_s, arrive_s})
        2'b10:   inflight_nx = inflight_r + CW'(1);
        2'b01:   inflight_nx = inflight_r - CW'(1);
        default: inflight_nx = inflight_r;
      endcase
      case ({arrive_s, pop_s})
        2'b10:   count_nx = count_r + CW'(1);
        2'b01:   count_nx = count_r - CW'(1);
        default: count_nx = count_r;
      endcase
      if (arrive_s) begin
        wr_ptr_nx = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_nx = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nx = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_nx = rd_ptr_r;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= {CW{1'b0}};
      inflight_r <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      proto_r    <= 1'b0;
    end else begin
      count_r    <= count_nx;
      inflight_r <= inflight_nx;
      wr_ptr_r   <= wr_ptr_nx;
      rd_ptr_r   <= rd_ptr_nx;
      proto_r    <= proto_nx;
    end
  end

  // Payload storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (arrive_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  riscv_v_stage_rx_buffer_chk #(
    .DEPTH      (DEPTH),
    .NUM_STAGES (NUM_STAGES),
    .CW         (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .launch   (launch_s),
    .arrive   (arrive_s),
    .count    (count_r),
    .inflight (inflight_r)
  );

endmodule

// Invariant checker for the receive buffer's credit accounting.
module riscv_v_stage_rx_buffer_chk #(
  parameter int DEPTH      = 4,
  parameter int NUM_STAGES = 1,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          launch,
  input logic          arrive,
  input logic [CW-1:0] count,
  input logic [CW-1:0] inflight
);

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW:0] used_s;
  assign used_s = {1'b0, count} + {1'b0, inflight};

  // Credit invariants sampled on every active edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (used_s <= DEPTH_W);
      assert (!(arrive && (inflight == {CW{1'b0}})));
      assert (!(arrive && ({1'b0, count} == DEPTH_W)));
      assert (!(launch && (used_s == DEPTH_W)));
      assert (DEPTH >= NUM_STAGES + 1);
    end
  end

endmodule

// File: tb/tb_riscv_v_stage_rx_buffer.sv
// Scoreboard bench: two buffer instances (DEPTH 4 and 3) behind an emulated
// 2-stage delay line, checked against a queue-based occupancy/credit model.

module tb_riscv_v_stage_rx_buffer;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, flush, up_req, in_valid, out_ready;
  logic [8:0] in_data;
  logic       rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic       grant_a, ov_a, pe_a, grant_b, ov_b, pe_b;
  logic [8:0] od_a, od_b;
  logic [2:0] cnt_a, inf_a;
  logic [1:0] cnt_b, inf_b;

  riscv_v_stage_rx_buffer #(.DATA_W(9), .DEPTH(4), .NUM_STAGES(NS)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush), .up_req(up_req), .up_grant(grant_a),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov_a), .out_data(od_a),
    .out_ready(out_ready), .count(cnt_a), .inflight(inf_a), .proto_err(pe_a));

  riscv_v_stage_rx_buffer #(.DATA_W(9), .DEPTH(3), .NUM_STAGES(NS)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush), .up_req(up_req), .up_grant(grant_b),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov_b), .out_data(od_b),
    .out_ready(out_ready), .count(cnt_b), .inflight(inf_b), .proto_err(pe_b));

  logic       act_grant, act_ov, act_pe;
  logic [8:0] act_od;
  int         act_cnt, act_inf;
  assign act_grant = sel ? grant_b : grant_a;
  assign act_ov    = sel ? ov_b : ov_a;
  assign act_pe    = sel ? pe_b : pe_a;
  assign act_od    = sel ? od_b : od_a;
  assign act_cnt   = sel ? int'(cnt_b) : int'(cnt_a);
  assign act_inf   = sel ? int'(inf_b) : int'(inf_a);

  int         n_chk = 0, n_fail = 0;
  int         depth, m_count, m_inflight, n_launch;
  bit         m_proto;
  logic [8:0] exp_q[$];
  bit         st_v[NS];
  logic [8:0] st_d[NS];
  logic [8:0] next_d;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pops the scoreboard whenever the consumer takes a beat.
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && act_ov && out_ready && !flush) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_order: popped %h with no beat expected", act_od);
        end else begin
          e = exp_q.pop_front();
          if (act_od !== e) begin
            n_fail++;
            $display("FAIL pop_data: got %h expected %h (t=%0t)", act_od, e, $time);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    rst = 1'b1; sel = s; up_req = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 9'h000;
    #1;
    chk("rst_count", act_cnt, 0);
    chk("rst_inflight", act_inf, 0);
    chk("rst_out_valid", int'(act_ov), 0);
    chk("rst_proto_err", int'(act_pe), 0);
    m_count = 0; m_inflight = 0; m_proto = 1'b0; n_launch = 0;
    exp_q.delete();
    for (int k = 0; k < NS; k++) st_v[k] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, then advance model and delay line.
  task automatic cycle(input bit req, input bit rdy, input bit fl, input bit inj, input logic [8:0] inj_d);
    bit iv, exp_g, arr, pop;
    @(negedge clk);
    iv = st_v[NS-1] || inj;
    up_req = req; out_ready = rdy; flush = fl; in_valid = iv;
    in_data = st_v[NS-1] ? st_d[NS-1] : inj_d;
    #1;
    chk("count", act_cnt, m_count);
    chk("inflight", act_inf, m_inflight);
    chk("out_valid", int'(act_ov), int'(m_count != 0));
    chk("proto_err", int'(act_pe), int'(m_proto));
    exp_g = req && !fl && (m_count + m_inflight < depth);
    chk("up_grant", int'(act_grant), int'(exp_g));
    if (exp_g) begin
      exp_q.push_back(next_d);
      n_launch++;
    end
    if (fl) begin
      m_count = 0; m_inflight = 0;
      exp_q.delete();
      for (int k = 0; k < NS; k++) st_v[k] = 1'b0;
    end else begin
      arr = iv && (m_inflight > 0);
      if (iv && m_inflight == 0) m_proto = 1'b1;
      pop = (m_count > 0) && rdy;
      m_count    = m_count + int'(arr) - int'(pop);
      m_inflight = m_inflight + int'(exp_g) - int'(arr);
      for (int k = NS-1; k > 0; k--) begin
        st_v[k] = st_v[k-1];
        st_d[k] = st_d[k-1];
      end
      st_v[0] = exp_g;
      st_d[0] = next_d;
    end
    if (exp_g) next_d = next_d + 9'h001;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; flush = 1'b0; up_req = 1'b0; in_valid = 1'b0;
    in_data = 9'h000; out_ready = 1'b0; next_d = 9'h001; depth = 4;
    fork monitor(); join_none

    // Streaming at full rate.
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);

    // Consumer stall exhausts credits, then drains in order.
    do_reset(1'b0);
    next_d = 9'h001;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);

    // Simultaneous push/pop at count==3 with write-pointer wrap.
    do_reset(1'b0);
    next_d = 9'h001;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    next_d = 9'h1AA;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);

    // Flush with count==2, inflight==2 and a beat emerging.
    next_d = 9'h020;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 9'h000);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);

    // Spurious arrival sets a sticky error that survives flush.
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 9'h155);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);

    // Random traffic with occasional flushes, then reset while busy.
    do_reset(1'b0);
    for (int i = 0; i < 80; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, 1'b0, 9'h000);
    do_reset(1'b0);

    // DEPTH=3 instance: 10 beats against a randomly stalling consumer.
    do_reset(1'b1);
    depth = 3;
    next_d = 9'h001;
    for (int i = 0; i < 200; i++) begin
      if (n_launch >= 10 && exp_q.size() == 0) break;
      cycle(n_launch < 10, $urandom_range(0, 2) != 0, 1'b0, 1'b0, 9'h000);
    end
    chk("b_launched", n_launch, 10);
    chk("b_drained", exp_q.size(), 0);
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, 1'b0, 9'h000);
    do_reset(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
